// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Scoreboard hazard detector for the ID stage. It keeps a
//                pending-writer counter for every architectural register and
//                asks IF/ID to stall while a source operand is not yet safe
//                to read.
//                  fu_en=0 : stall while any writer of a source is in flight
//                  fu_en=1 : stall only on a load-use in the load's EXE cycle
//                A writer whose destination already has MAX_INFLIGHT
//                outstanding writers is always stalled.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                fu_en               forwarding mode select
//                flush_all           squash in-flight work, clear scoreboard
//                id_valid, id_src, id_src_vld, id_wb_en, id_dst, id_mem_r
//                                    ID-stage instruction description
//                wb_en, wb_dst       WB-stage register retire
//                hazard              combinational stall request
//                busy_mask           registered per-register "pending" flags
//                err_underflow       sticky retire-without-writer flag
//                stall_cycles        saturating count of stalled ID cycles
//  Config      : HAZARD_SB_STATS_EN  defined   -> stall_cycles counter built
//                                    undefined -> stall_cycles tied to 0
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 4,
    parameter int NUM_SRC      = 3,
    parameter int MAX_INFLIGHT = 3,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fu_en,
    input  logic                               flush_all,
    input  logic                               id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]      id_src,
    input  logic [NUM_SRC-1:0]                 id_src_vld,
    input  logic                               id_wb_en,
    input  logic [REG_ADDR_W-1:0]              id_dst,
    input  logic                               id_mem_r,
    input  logic                               wb_en,
    input  logic [REG_ADDR_W-1:0]              wb_dst,
    output logic                               hazard,
    output logic [(2**REG_ADDR_W)-1:0]         busy_mask,
    output logic                               err_underflow,
    output logic [STALL_CNT_W-1:0]             stall_cycles
);

    localparam int c_num_regs = 2**REG_ADDR_W;
    localparam int c_cnt_w    = $clog2(MAX_INFLIGHT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_INFLIGHT);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [0:0] {
        LS_IDLE = 1'b0,
        LS_EXE  = 1'b1
    } ls_state_t;

    ls_state_t               r_ls_state;
    ls_state_t               w_ls_state_nxt;
    logic [REG_ADDR_W-1:0]   r_ld_dst;
    logic [REG_ADDR_W-1:0]   w_ld_dst_nxt;

    logic [c_cnt_w-1:0]      r_pend_cnt [c_num_regs];
    logic [c_cnt_w-1:0]      w_cnt_nxt  [c_num_regs];
    logic [c_num_regs-1:0]   w_busy_nxt;
    logic [c_num_regs-1:0]   w_uflow;

    logic [NUM_SRC-1:0]      w_src_hit;
    logic [NUM_SRC-1:0]      w_ldu_hit;
    logic                    w_full_hit;
    logic                    w_issue;
    logic                    w_retire;

    // ------------------------------------------------------------------
    // Per-source hit detection
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            logic [REG_ADDR_W-1:0] w_src;
            assign w_src        = id_src[k*REG_ADDR_W +: REG_ADDR_W];
            assign w_src_hit[k] = id_src_vld[k] & (r_pend_cnt[w_src] != '0);
            assign w_ldu_hit[k] = id_src_vld[k] & (r_ls_state == LS_EXE)
                                  & (w_src == r_ld_dst);
        end
    endgenerate

    assign w_full_hit = id_wb_en & (r_pend_cnt[id_dst] == c_cnt_max);

    // The register's own retire this cycle is deliberately not used to
    // release the stall: the reader waits until the counter has dropped.
    assign hazard   = id_valid & ~flush_all
                      & (w_full_hit | (fu_en ? (|w_ldu_hit) : (|w_src_hit)));
    assign w_issue  = id_valid & id_wb_en & ~hazard & ~flush_all;
    // Flush wins over a retire arriving in the same cycle.
    assign w_retire = wb_en & ~flush_all;

    // ------------------------------------------------------------------
    // Pending-writer counters
    // ------------------------------------------------------------------
    generate
        for (genvar r = 0; r < c_num_regs; r++) begin : g_reg
            localparam logic [REG_ADDR_W-1:0] c_idx = REG_ADDR_W'(r);
            logic w_inc;
            logic w_dec;

            assign w_inc      = w_issue  & (id_dst == c_idx);
            assign w_dec      = w_retire & (wb_dst == c_idx);
            assign w_uflow[r] = w_dec & ~w_inc & (r_pend_cnt[r] == '0);

            // Increment cannot overflow: an issue to a full register is
            // blocked by w_full_hit. A retire of an empty register holds 0.
            assign w_cnt_nxt[r] =
                flush_all                                  ? '0 :
                (w_inc & ~w_dec)                           ? r_pend_cnt[r] + c_cnt_one :
                (w_dec & ~w_inc & (r_pend_cnt[r] != '0))   ? r_pend_cnt[r] - c_cnt_one :
                                                             r_pend_cnt[r];
            assign w_busy_nxt[r] = (w_cnt_nxt[r] != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_num_regs; i++) begin
                r_pend_cnt[i] <= '0;
            end
            busy_mask     <= '0;
            err_underflow <= 1'b0;
        end else begin
            r_pend_cnt    <= w_cnt_nxt;
            // Registered from the next-state counters so it lines up with them.
            busy_mask     <= w_busy_nxt;
            err_underflow <= err_underflow | (|w_uflow);
        end
    end

    // ------------------------------------------------------------------
    // Load shadow FSM: marks the single EXE cycle of the latest load
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ls_state <= LS_IDLE;
            r_ld_dst   <= '0;
        end else begin
            r_ls_state <= w_ls_state_nxt;
            r_ld_dst   <= w_ld_dst_nxt;
        end
    end

    always_comb begin
        w_ls_state_nxt = LS_IDLE;
        w_ld_dst_nxt   = r_ld_dst;
        // w_issue is already suppressed by flush_all, so a flush lands in IDLE.
        if (w_issue && id_mem_r) begin
            w_ls_state_nxt = LS_EXE;
            w_ld_dst_nxt   = id_dst;
        end
    end

    // ------------------------------------------------------------------
    // Optional stall statistics
    // ------------------------------------------------------------------
`ifdef HAZARD_SB_STATS_EN
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (id_valid && hazard && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire
